instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
- REQ-001: Parameter PC_W, default 4, program-counter and memory-address width.
- REQ-002: Parameter INSTR_W, default 8, instruction word width.
- REQ-003: Parameter DEPTH, default 4, prefetch queue entries, power of two, at least 2.
- REQ-004: clk  input  1  sole clock; all state updates on rising edge.
- REQ-005: reset  input  1  asynchronous, active-low; low clears all state immediately.
- REQ-006: mem_req  output  1  program-memory read request.
- REQ-007: mem_addr  output  PC_W  read address; valid while mem_req=1.
- REQ-008: mem_ack  input  1  memory returns mem_data this cycle; ignored when mem_req=0.
- REQ-009: mem_data  input  INSTR_W  instruction word; sampled when mem_req=1 and mem_ack=1.
- REQ-010: instr_valid  output  1  queue head holds an instruction for the decoder.
- REQ-011: instr_ready  input  1  decoder accepts the head this cycle.
- REQ-012: instruction  output  INSTR_W  queue-head instruction word.
- REQ-013: instr_pc  output  PC_W  address the head instruction was fetched from.
- REQ-014: branch_load  input  1  redirect fetch; flush the queue.
- REQ-015: branch_addr  input  PC_W  new fetch address; sampled when branch_load=1.

Function
- REQ-016: The block SHALL contain a registered fetch_pc, a DEPTH-entry FIFO of {pc, instruction} pairs, and a three-state FSM: IDLE, WAIT, DISCARD.
- REQ-017: In IDLE, with entry count < DEPTH and branch_load=0, the block SHALL move to WAIT and drive mem_req=1, mem_addr=fetch_pc from the next cycle.
- REQ-018: In WAIT, mem_req and mem_addr SHALL remain stable until the cycle mem_ack=1.
- REQ-019: On mem_ack in WAIT, the block SHALL push {fetch_pc, mem_data} and increment fetch_pc modulo 2^PC_W (15 wraps to 0).
- REQ-020: After the mem_ack, the FSM SHALL return to IDLE and deassert mem_req the following cycle (minimum two cycles per fetch).
- REQ-021: instr_valid SHALL equal (count != 0); instruction and instr_pc SHALL show the head entry, or all zeros when empty.
- REQ-022: The block SHALL pop the head on a clock edge where instr_valid=1 and instr_ready=1.
- REQ-023: A simultaneous push and pop SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
- REQ-024: No push SHALL occur when full; a request SHALL issue only when count < DEPTH, so a full queue leaves the FSM in IDLE.
- REQ-025: branch_load=1 SHALL, in the same edge, empty the queue and set fetch_pc=branch_addr; any concurrent pop or push is discarded.
- REQ-026: branch_load in WAIT without mem_ack SHALL move the FSM to DISCARD, with mem_req/mem_addr held at the old address.
- REQ-027: branch_load in WAIT with mem_ack in the same cycle SHALL discard mem_data and move the FSM to IDLE.
- REQ-028: In DISCARD, mem_ack SHALL drop the returned data and move the FSM to IDLE; fetch_pc is not incremented.
- REQ-029: branch_load in DISCARD SHALL only update fetch_pc; the FSM stays in DISCARD.
- REQ-030: branch_load in IDLE SHALL keep the FSM in IDLE for that cycle.
- REQ-031: instr_valid SHALL be 0 the cycle after any branch_load.

Reset
- REQ-032: reset=0 SHALL force fetch_pc=0, FSM=IDLE, count=0, both pointers=0, and mem_req=0, mem_addr=0, instr_valid=0, instruction=0, instr_pc=0.
- REQ-033: reset asserted during WAIT SHALL abandon the request, and no data from a late mem_ack SHALL enter the queue.
- REQ-034: The first request after reset release SHALL use mem_addr=0.

Verification
- REQ-035: Reset release, instr_ready=1, zero-wait memory returning 8'hA0+addr -> decoder sees A0/pc0, A1/pc1, A2/pc2 in order, each one fetch period apart.
- REQ-036: instr_ready=0 for 20 cycles -> exactly DEPTH=4 entries (pc 0..3) queued, mem_req stays 0 once full, and no entry is lost after ready returns.
- REQ-037: fetch_pc=15 -> fetch at addr 15, then mem_addr=0; instr_pc reports 15 then 0.
- REQ-038: branch_load with branch_addr=9 while in WAIT, ack delayed 3 cycles -> mem_addr holds the old address until the ack, data dropped, next request at addr 9, first valid instr_pc=9.
- REQ-039: branch_load coincident with a pop and a mem_ack -> queue empty next cycle, neither entry delivered, next fetch from branch_addr.
- REQ-040: reset pulsed low mid-WAIT with queue holding 2 entries -> all outputs 0 immediately; after release, fetch restarts at 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch unit: fetches sequential words from program memory into a
// small FIFO for the decoder, with branch redirect that flushes queued and in-flight fetches.
module instr_fetch_queue #(
  parameter int unsigned PC_W    = 4,
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               branch_load,
  input  logic [PC_W-1:0]    branch_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t               state;
  logic [PC_W-1:0]      fetch_pc;
  logic [PC_W-1:0]      pc_mem   [DEPTH];
  logic [INSTR_W-1:0]   data_mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  logic                 push;
  logic                 pop;
  logic                 head_is_new;
  logic [CNT_W-1:0]     count_n;
  logic [PTR_W-1:0]     rd_ptr_n;
  logic [PTR_W-1:0]     wr_ptr_n;
  logic [PC_W-1:0]      head_pc_n;
  logic [INSTR_W-1:0]   head_data_n;

  // Queue bookkeeping and next head; a branch overrides any push or pop in the same edge.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    head_is_new = 1'b0;
    count_n     = count;
    rd_ptr_n    = rd_ptr;
    wr_ptr_n    = wr_ptr;
    head_pc_n   = '0;
    head_data_n = '0;

    push = (state == S_WAIT) && mem_ack && !branch_load && (count < CNT_W'(DEPTH));
    pop  = instr_valid && instr_ready && !branch_load;

    if (branch_load) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end else begin
      count_n  = count + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_n = rd_ptr + PTR_W'(pop);
      wr_ptr_n = wr_ptr + PTR_W'(push);
    end

    // The entry being written becomes the head when nothing older survives this edge.
    head_is_new = push && ((count == '0) || (pop && (count == CNT_W'(1))));

    if (count_n != '0) begin
      if (head_is_new) begin
        head_pc_n   = fetch_pc;
        head_data_n = mem_data;
      end else begin
        head_pc_n   = pc_mem[rd_ptr_n];
        head_data_n = data_mem[rd_ptr_n];
      end
    end
  end

  // Fetch FSM, fetch PC, FIFO storage and registered decoder-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      fetch_pc    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      count       <= count_n;
      rd_ptr      <= rd_ptr_n;
      wr_ptr      <= wr_ptr_n;
      instr_valid <= (count_n != '0);
      instr_pc    <= head_pc_n;
      instruction <= head_data_n;

      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        data_mem[wr_ptr] <= mem_data;
      end

      if (branch_load) begin
        fetch_pc <= branch_addr;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (!branch_load && (count < CNT_W'(DEPTH))) begin
            state    <= S_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        S_WAIT: begin
          // Request stays on the bus until acknowledged; a branch only marks it stale.
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end else if (branch_load) begin
            state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory model returning A0+addr, scoreboard of
// expected {pc, instruction} pairs filled at each accepted fetch and drained at each pop.
module tb_instr_fetch_queue;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instruction;
  logic [3:0] instr_pc;
  logic       branch_load;
  logic [3:0] branch_addr;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ins;
  } ent_t;

  ent_t       exp_q[$];
  int         pop_cyc[$];
  logic [3:0] exp_pc;
  bit         discard;
  bit         mon_en;
  bit         mem_en;
  int         n_acks;
  int         cyc;
  int         n_checks;
  int         n_fail;
  logic [3:0] old_addr;

  instr_fetch_queue #(.PC_W(4), .INSTR_W(8), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .branch_load (branch_load),
    .branch_addr (branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack  = mem_req & mem_en;
  assign mem_data = 8'hA0 + {4'h0, mem_addr};

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!mem_req && k < 40) begin
      cycle();
      k++;
    end
    check(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_pc  = 4'h0;
    discard = 1'b0;
    n_acks  = 0;
  endtask

  // Inputs are stable at the falling edge, so predict what the next rising edge does.
  always @(negedge clk) begin
    ent_t e;
    if (mon_en && reset) begin
      check("valid_vs_model", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (instr_valid && instr_ready && !branch_load) begin
        if (exp_q.size() == 0) begin
          check("pop_underflow", 32'(instr_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("head_pc", 32'(instr_pc), 32'(e.pc));
          check("head_instr", 32'(instruction), 32'(e.ins));
          pop_cyc.push_back(cyc);
        end
      end
      if (mem_req && mem_ack) begin
        if (branch_load || discard) begin
          discard = 1'b0;
        end else begin
          check("fetch_addr", 32'(mem_addr), 32'(exp_pc));
          exp_q.push_back({exp_pc, 8'hA0 + {4'h0, exp_pc}});
          exp_pc = exp_pc + 4'd1;
          n_acks++;
        end
      end
      if (branch_load) begin
        exp_q.delete();
        exp_pc = branch_addr;
        if (mem_req && !mem_ack) discard = 1'b1;
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    mem_en      = 1'b1;
    reset       = 1'b1;
    instr_ready = 1'b0;
    branch_load = 1'b0;
    branch_addr = 4'h0;
    model_clear();
    #1 reset = 1'b0;
    repeat (2) cycle();
    mon_en = 1'b1;

    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);

    // Zero-wait streaming from reset
    pop_cyc.delete();
    instr_ready = 1'b1;
    reset = 1'b1;
    cycle();
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'd0);
    repeat (8) cycle();
    check("stream_pops", 32'(pop_cyc.size() >= 3), 32'd1);
    if (pop_cyc.size() >= 3) begin
      check("period_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      check("period_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end

    // Decoder stalled: queue fills to DEPTH and fetching stops
    reset = 1'b0;
    model_clear();
    repeat (2) cycle();
    instr_ready = 1'b0;
    reset = 1'b1;
    repeat (20) cycle();
    check("full_fetches", 32'(n_acks), 32'd4);
    check("full_no_req", 32'(mem_req), 32'd0);
    check("full_head_pc", 32'(instr_pc), 32'd0);
    check("full_head_ins", 32'(instruction), 32'hA0);
    repeat (3) begin
      cycle();
      check("full_req_stays0", 32'(mem_req), 32'd0);
    end
    instr_ready = 1'b1;
    repeat (14) cycle();

    // PC wrap 15 -> 0
    branch_addr = 4'd14;
    branch_load = 1'b1;
    cycle();
    branch_load = 1'b0;
    check("br_valid0", 32'(instr_valid), 32'd0);
    repeat (12) cycle();

    // Branch while a fetch is outstanding; ack arrives three cycles later
    mem_en = 1'b0;
    wait_req("stall_req");
    old_addr = exp_pc;
    branch_addr = 4'd9;
    branch_load = 1'b1;
    cycle();
    branch_load = 1'b0;
    check("disc_valid0", 32'(instr_valid), 32'd0);
    repeat (3) begin
      check("disc_req_held", 32'(mem_req), 32'd1);
      check("disc_addr_held", 32'(mem_addr), 32'(old_addr));
      cycle();
    end
    mem_en = 1'b1;
    cycle();
    check("disc_req_drop", 32'(mem_req), 32'd0);
    wait_req("after_disc_req");
    check("after_disc_addr", 32'(mem_addr), 32'd9);
    repeat (8) cycle();

    // Branch coincident with a pop and a mem_ack
    instr_ready = 1'b0;
    repeat (6) cycle();
    instr_ready = 1'b1;
    wait_req("coinc_req");
    check("coinc_pre_valid", 32'(instr_valid), 32'd1);
    branch_addr = 4'd5;
    branch_load = 1'b1;
    cycle();
    branch_load = 1'b0;
    check("coinc_valid0", 32'(instr_valid), 32'd0);
    check("coinc_instr0", 32'(instruction), 32'd0);
    check("coinc_pc0", 32'(instr_pc), 32'd0);
    check("coinc_req0", 32'(mem_req), 32'd0);
    wait_req("coinc_next_req");
    check("coinc_next_addr", 32'(mem_addr), 32'd5);
    repeat (8) cycle();

    // Reset mid-WAIT with two queued entries
    instr_ready = 1'b0;
    begin
      int k = 0;
      while (exp_q.size() < 2 && k < 40) begin
        cycle();
        k++;
      end
    end
    mem_en = 1'b0;
    wait_req("midrst_req");
    check("midrst_pre_valid", 32'(instr_valid), 32'd1);
    #2 reset = 1'b0;
    model_clear();
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr", 32'(instruction), 32'd0);
    check("midrst_pc", 32'(instr_pc), 32'd0);
    mem_en = 1'b1;
    repeat (2) cycle();
    check("midrst_late_ack", 32'(instr_valid), 32'd0);
    reset = 1'b1;
    instr_ready = 1'b1;
    cycle();
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'd0);
    repeat (6) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
